// File: rtl/tinyrv1_mem_pkg.sv
// Shared types for the TinyRV1 instruction-memory responder.
package tinyrv1_mem_pkg;

  localparam int BYTE_OFF_W = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } imem_resp_t;

endpackage

// File: rtl/Register.sv
// Enabled register with asynchronous active-low clear to zero.
module Register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/imem_resp_queue2.sv
// Two-entry in-order response FIFO; head reads as zero while empty.
module imem_resp_queue2
  import tinyrv1_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enq,
  input  imem_resp_t enq_data,
  input  logic       deq,
  output imem_resp_t head,
  output logic       full,
  output logic       empty
);

  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       do_enq;
  logic       do_deq;
  imem_resp_t entry0;
  imem_resp_t entry1;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;

  assign count_next = count + {1'b0, do_enq} - {1'b0, do_deq};

  Register #(.WIDTH(2)) u_count (
    .clk(clk), .rst(rst), .en(do_enq | do_deq), .d(count_next), .q(count)
  );

  Register #(.WIDTH(1)) u_wptr (
    .clk(clk), .rst(rst), .en(do_enq), .d(~wptr), .q(wptr)
  );

  Register #(.WIDTH(1)) u_rptr (
    .clk(clk), .rst(rst), .en(do_deq), .d(~rptr), .q(rptr)
  );

  Register #(.WIDTH($bits(imem_resp_t))) u_entry0 (
    .clk(clk), .rst(rst), .en(do_enq & ~wptr), .d(enq_data), .q(entry0)
  );

  Register #(.WIDTH($bits(imem_resp_t))) u_entry1 (
    .clk(clk), .rst(rst), .en(do_enq & wptr), .d(enq_data), .q(entry1)
  );

  always_comb begin
    head = '0;
    if (!empty)
      head = rptr ? entry1 : entry0;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array, request decode/error check,
// program-load port, and a 2-entry response queue for back-pressure.
module imem_responder
  import tinyrv1_mem_pkg::*;
#(
  parameter int NUM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,
  output logic [31:0] imemresp_data,
  output logic        imemresp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int WADR_W = 32 - BYTE_OFF_W;

  logic [31:0]      mem [NUM_WORDS];
  logic             alive;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             load_ok;
  logic [IDX_W-1:0] load_idx;
  logic             accept;
  logic             q_full;
  logic             q_empty;
  imem_resp_t       enq_entry;
  imem_resp_t       head;

  // Holds the request port closed until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      alive <= 1'b0;
    else
      alive <= 1'b1;
  end

  assign req_err = (|imemreq_addr[BYTE_OFF_W-1:0]) |
                   (imemreq_addr[31:BYTE_OFF_W] >= WADR_W'(NUM_WORDS));
  assign req_idx = imemreq_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

  assign load_ok  = ~(|load_addr[BYTE_OFF_W-1:0]) &
                    (load_addr[31:BYTE_OFF_W] < WADR_W'(NUM_WORDS));
  assign load_idx = load_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

  // Read happens before the write lands, so a same-edge load is not seen.
  always_comb begin
    enq_entry      = '0;
    enq_entry.err  = req_err;
    if (!req_err)
      enq_entry.data = mem[req_idx];
  end

  always_ff @(posedge clk) begin
    if (load_en && load_ok)
      mem[load_idx] <= load_data;
  end

  assign imemreq_rdy = alive & ~q_full;
  assign accept      = imemreq_val & imemreq_rdy;

  imem_resp_queue2 u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (accept),
    .enq_data (enq_entry),
    .deq      (imemresp_rdy),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign imemresp_val  = ~q_empty;
  assign imemresp_data = head.data;
  assign imemresp_err  = head.err;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the TinyRV1 pipelined processor: the far end of the fetch-stage `imemreq`/`imemresp` interface the processor control drives. It accepts word-aligned fetch requests over a val/rdy handshake, reads a synchronous word array, and returns in-order responses through a 2-entry response queue so the processor may back-pressure. A side write port lets the test harness load programs.

## Interface
- `NUM_WORDS`, 256: memory depth in 32-bit words; power of two, ≥ 4.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low (`rst`=0 resets).
- `imemreq_val` in 1: request valid.
- `imemreq_rdy` out 1: responder can accept a request.
- `imemreq_addr` in 32: byte address of fetch.
- `imemresp_val` out 1: response valid (queue head).
- `imemresp_rdy` in 1: processor consumes response.
- `imemresp_data` out 32: fetched word; 0 when `imemresp_err`=1.
- `imemresp_err` out 1: request was misaligned or out of range.
- `load_en` in 1: program-load write strobe.
- `load_addr` in 32: byte address of load write.
- `load_data` in 32: word to write.

## Operation
- Word index = `addr[IDX_W+1:2]`, `IDX_W` = clog2(`NUM_WORDS`).
- Request accepted on an edge where `imemreq_val & imemreq_rdy`.
- Accepted request enqueues {err, data} into response queue at that same edge; array read and error check complete in the accept cycle.
- err = (`addr[1:0]` != 0) | (`addr[31:2]` ≥ `NUM_WORDS`); on err, data = 0 and the array is not accessed.
- Response dequeued on edge where `imemresp_val & imemresp_rdy`.
- Queue: 2 entries, FIFO order strictly preserved; count ∈ {0,1,2}.
- `imemreq_rdy` = (count < 2); registered-state-only, no combinational path from `imemresp_rdy`.
- `imemresp_val` = (count > 0); data/err show head entry and are stable while val=1 and rdy=0.
- Enq and deq on same edge: count unchanged, head advances, new entry at tail.
- Load: `load_en`=1 writes `load_data` to word index at edge; misaligned or out-of-range load writes are dropped silently.
- Load and request to same word on same edge: response carries old (pre-write) data.
- `imemreq_val` with `imemreq_rdy`=0: no effect; requester must hold request.
- Array contents not affected by reset; undefined until loaded.

## Timing
- Reset values: `imemreq_rdy`=0 while `rst`=0, 1 in first cycle after release; `imemresp_val`=0, `imemresp_data`=0, `imemresp_err`=0; count=0, queue pointers=0.
- Reset asserted mid-operation: queue flushes immediately (async), in-flight responses lost; memory retained.
- Latency: request accepted in cycle N -> `imemresp_val`=1 in cycle N+1.
- Throughput: one request/cycle sustained when `imemresp_rdy` held 1 (steady count=1).
- Full: after 2 accepts with no deq, `imemreq_rdy`=0 next cycle; returns to 1 the cycle after the first deq.
- Empty: `imemresp_data`/`imemresp_err` driven 0 when count=0.
- Pointer wrap: 1-bit read/write pointers wrap 1->0.

## Structure
- Shared package `tinyrv1_mem_pkg`: typedef `imem_resp_t` {err, data[31:0]}; constant for word-aligned byte offset width (2).
- Sub-module `imem_resp_queue2`: 2-entry FIFO of `imem_resp_t`, enq/deq/full/empty, built from `Register` instances with async active-low reset.
- Top holds array, address decode, error check, load port.

## Test plan
- Reset then load words 0x00000013 @0x0, 0xDEADBEEF @0x4; requests 0x0,0x4 back-to-back, `imemresp_rdy`=1 -> responses 0x00000013, 0xDEADBEEF in cycles N+1, N+2, err=0.
- Hold `imemresp_rdy`=0, request 0x0,0x4,0x8 -> first two accepted, `imemreq_rdy`=0 from cycle after second accept, third held; raise rdy -> three responses in order.
- Request 0x2 and 0x400 (NUM_WORDS=256) -> two responses err=1, data=0; memory unchanged.
- Same-edge load 0x12345678 @0x8 and request 0x8 (old 0xCAFEF00D) -> response 0xCAFEF00D; next request 0x8 -> 0x12345678.
- Full queue, assert `rst`=0 mid-cycle -> `imemresp_val`=0 immediately; after release `imemreq_rdy`=1 next cycle, reads of 0x4 still 0xDEADBEEF.
